// File: rtl/bcd_stopwatch_ctrl_if.sv
// bcd_stopwatch_ctrl_if: command and display bundle for the BCD stopwatch controller
//   i_start/i_stop/i_clear/i_lap : one-cycle command pulses
//   i_target                     : packed BCD alarm value, 0 disables the alarm
//   o_cnt/o_lap                  : running count and last captured lap, packed BCD
//   o_running/o_done             : registered state decodes
//   o_ovf/o_tick                 : one-cycle event pulses
interface bcd_stopwatch_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      i_start;
    logic                      i_stop;
    logic                      i_clear;
    logic                      i_lap;
    logic [4*NUM_DIGITS-1:0]   i_target;
    logic [4*NUM_DIGITS-1:0]   o_cnt;
    logic [4*NUM_DIGITS-1:0]   o_lap;
    logic                      o_running;
    logic                      o_done;
    logic                      o_ovf;
    logic                      o_tick;
    modport master (
        output i_start, i_stop, i_clear, i_lap, i_target,
        input  o_cnt, o_lap, o_running, o_done, o_ovf, o_tick
    );
    modport slave (
        input  i_start, i_stop, i_clear, i_lap, i_target,
        output o_cnt, o_lap, o_running, o_done, o_ovf, o_tick
    );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl: start/stop/lap BCD stopwatch with prescaler, overflow and target alarm
//   i_clk  : clock
//   i_sclr : synchronous active-high reset
//   bus    : bcd_stopwatch_ctrl_if slave (commands, target, count/lap/status outputs)
module bcd_stopwatch_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 1000,
    parameter int DIV_WIDTH  = 10
) (
    input  logic                  i_clk,
    input  logic                  i_sclr,
    bcd_stopwatch_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;
    state_t                  r_state;
    state_t                  w_next;
    logic [DIV_WIDTH-1:0]    r_pre;
    logic [DIV_WIDTH-1:0]    w_pre_nxt;
    logic [4*NUM_DIGITS-1:0] r_cnt;
    logic [4*NUM_DIGITS-1:0] r_lap;
    logic [4*NUM_DIGITS-1:0] w_cnt_nxt;
    logic                    r_running;
    logic                    r_done;
    logic                    r_ovf;
    logic                    r_tick;
    logic                    w_adv;
    logic                    w_wrap;
    logic                    w_carry;
    logic                    w_match;
    assign w_adv     = r_state == S_RUN && !bus.i_stop && !bus.i_clear;
    assign w_wrap    = w_adv && r_pre == DIV_WIDTH'(TICK_DIV - 1);
    assign w_pre_nxt = bus.i_clear ? '0 : w_wrap ? '0 : w_adv ? r_pre + DIV_WIDTH'(1) : r_pre;
    // Ripple carry: digit k advances only when every lower digit is 9; w_carry ends as the wrap flag.
    always_comb begin
        w_carry = w_wrap;
        w_cnt_nxt = r_cnt;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_cnt_nxt[4*k+:4] = !w_carry ? r_cnt[4*k+:4] : r_cnt[4*k+:4] == 4'd9 ? 4'd0 : r_cnt[4*k+:4] + 4'd1;
            w_carry = w_carry && r_cnt[4*k+:4] == 4'd9;
        end
    end
    // Only evaluated on a tick, so a target already passed waits for the wrap; the post-wrap zero never matches.
    assign w_match = w_wrap && |bus.i_target && w_cnt_nxt == bus.i_target;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = bus.i_start ? S_RUN : S_IDLE;
            S_RUN:   w_next = bus.i_stop ? S_PAUSE : w_match ? S_DONE : S_RUN;
            S_PAUSE: w_next = bus.i_start ? S_RUN : S_PAUSE;
            default: w_next = S_DONE;
        endcase
        if (bus.i_clear) w_next = S_IDLE;
    end
    always_ff @(posedge i_clk) begin
        if (i_sclr) begin
            r_state   <= S_IDLE;
            r_pre     <= '0;
            r_cnt     <= '0;
            r_lap     <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_pre     <= w_pre_nxt;
            r_cnt     <= bus.i_clear ? '0 : w_cnt_nxt;
            r_lap     <= bus.i_clear ? '0 : bus.i_lap ? r_cnt : r_lap;
            r_running <= w_next == S_RUN;
            r_done    <= w_next == S_DONE;
            r_ovf     <= w_carry;
            r_tick    <= w_wrap;
        end
    end
    assign bus.o_cnt     = r_cnt;
    assign bus.o_lap     = r_lap;
    assign bus.o_running = r_running;
    assign bus.o_done    = r_done;
    assign bus.o_ovf     = r_ovf;
    assign bus.o_tick    = r_tick;
endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// tb_bcd_stopwatch_ctrl: directed plus random stimulus against an integer-count stopwatch model
module tb_bcd_stopwatch_ctrl;
    localparam int ND  = 2;
    localparam int DIV = 4;
    localparam int MAXV = 100;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    logic clk = 1'b0;
    logic sclr = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   m_cnt, m_lap, m_phase, m_mode;
    bit   m_tick, m_ovf;
    bcd_stopwatch_ctrl_if #(.NUM_DIGITS(ND)) sw ();
    bcd_stopwatch_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(DIV), .DIV_WIDTH(2)) dut (
        .i_clk (clk),
        .i_sclr(sclr),
        .bus   (sw)
    );
    always #5 clk = ~clk;
    function automatic logic [4*ND-1:0] to_bcd(input int v);
        logic [4*ND-1:0] r;
        int p = 1;
        for (int k = 0; k < ND; k++) begin
            r[4*k+:4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction
    function automatic int from_bcd(input logic [4*ND-1:0] t);
        int v = 0;
        int p = 1;
        for (int k = 0; k < ND; k++) begin
            if (t[4*k+:4] > 4'd9) return -1;
            v = v + int'(t[4*k+:4]) * p;
            p = p * 10;
        end
        return v;
    endfunction
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic step();
        int tv = from_bcd(sw.i_target);
        m_tick = 0;
        m_ovf = 0;
        if (sclr || sw.i_clear) begin
            m_cnt = 0;
            m_lap = 0;
            m_phase = 0;
            m_mode = M_IDLE;
        end else begin
            if (sw.i_lap) m_lap = m_cnt;
            if (m_mode == M_IDLE && sw.i_start) m_mode = M_RUN;
            else if (m_mode == M_PAUSE && sw.i_start) m_mode = M_RUN;
            else if (m_mode == M_RUN && sw.i_stop) m_mode = M_PAUSE;
            else if (m_mode == M_RUN) begin
                m_phase++;
                if (m_phase == DIV) begin
                    m_phase = 0;
                    m_tick = 1;
                    m_cnt = (m_cnt + 1) % MAXV;
                    m_ovf = m_cnt == 0;
                    if (tv > 0 && m_cnt == tv) m_mode = M_DONE;
                end
            end
        end
        @(posedge clk);
        #1;
        check("cnt", 32'(sw.o_cnt), 32'(to_bcd(m_cnt)));
        check("lap", 32'(sw.o_lap), 32'(to_bcd(m_lap)));
        check("running", 32'(sw.o_running), 32'(m_mode == M_RUN));
        check("done", 32'(sw.o_done), 32'(m_mode == M_DONE));
        check("ovf", 32'(sw.o_ovf), 32'(m_ovf));
        check("tick", 32'(sw.o_tick), 32'(m_tick));
    endtask
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) step();
    endtask
    task automatic start_pulse();
        sw.i_start = 1'b1;
        step();
        sw.i_start = 1'b0;
    endtask
    task automatic clear_pulse();
        sw.i_clear = 1'b1;
        step();
        sw.i_clear = 1'b0;
    endtask
    initial begin
        sw.i_start = 1'b0;
        sw.i_stop = 1'b0;
        sw.i_clear = 1'b0;
        sw.i_lap = 1'b0;
        sw.i_target = '0;
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        check("rst_cnt", 32'(sw.o_cnt), 32'h0);
        check("rst_run", 32'(sw.o_running), 32'h0);
        start_pulse();
        check("start_run", 32'(sw.o_running), 32'h1);
        cyc(3);
        check("pre_first_tick", 32'(sw.o_tick), 32'h0);
        step();
        check("first_tick", 32'(sw.o_tick), 32'h1);
        check("first_cnt", 32'(sw.o_cnt), 32'h01);
        cyc(40);
        check("cnt_11", 32'(sw.o_cnt), 32'h11);
        cyc(88 * DIV + DIV - 1);
        step();
        check("wrap_cnt", 32'(sw.o_cnt), 32'h00);
        check("wrap_ovf", 32'(sw.o_ovf), 32'h1);
        check("wrap_run", 32'(sw.o_running), 32'h1);
        step();
        check("ovf_one_cycle", 32'(sw.o_ovf), 32'h0);
        clear_pulse();
        sw.i_target = 8'h07;
        start_pulse();
        cyc(27);
        check("pre_target_done", 32'(sw.o_done), 32'h0);
        step();
        check("target_cnt", 32'(sw.o_cnt), 32'h07);
        check("target_done", 32'(sw.o_done), 32'h1);
        start_pulse();
        check("done_ignores_start", 32'(sw.o_done), 32'h1);
        clear_pulse();
        check("clear_cnt", 32'(sw.o_cnt), 32'h0);
        check("clear_idle", 32'(sw.o_done | sw.o_running), 32'h0);
        sw.i_target = '0;
        start_pulse();
        cyc(6);
        sw.i_stop = 1'b1;
        step();
        sw.i_stop = 1'b0;
        cyc(20);
        check("pause_cnt", 32'(sw.o_cnt), 32'h01);
        start_pulse();
        step();
        check("resume_no_tick", 32'(sw.o_tick), 32'h0);
        step();
        check("resume_tick", 32'(sw.o_tick), 32'h1);
        check("resume_cnt", 32'(sw.o_cnt), 32'h02);
        clear_pulse();
        start_pulse();
        cyc(35 * DIV + DIV - 1);
        sw.i_lap = 1'b1;
        step();
        check("lap_tick_lap", 32'(sw.o_lap), 32'h35);
        check("lap_tick_cnt", 32'(sw.o_cnt), 32'h36);
        sw.i_clear = 1'b1;
        step();
        sw.i_lap = 1'b0;
        sw.i_clear = 1'b0;
        check("lap_clear_lap", 32'(sw.o_lap), 32'h0);
        check("lap_clear_cnt", 32'(sw.o_cnt), 32'h0);
        start_pulse();
        cyc(5);
        sclr = 1'b1;
        sw.i_start = 1'b1;
        step();
        sclr = 1'b0;
        sw.i_start = 1'b0;
        check("sclr_run", 32'(sw.o_running), 32'h0);
        check("sclr_cnt", 32'(sw.o_cnt), 32'h0);
        start_pulse();
        cyc(3);
        sw.i_clear = 1'b1;
        sw.i_start = 1'b1;
        step();
        sw.i_clear = 1'b0;
        sw.i_start = 1'b0;
        check("clear_beats_start", 32'(sw.o_running), 32'h0);
        for (int i = 0; i < 4000; i++) begin
            sw.i_start = $urandom_range(0, 7) == 0;
            sw.i_stop = !sw.i_start && $urandom_range(0, 15) == 0;
            sw.i_clear = $urandom_range(0, 511) == 0;
            sw.i_lap = $urandom_range(0, 7) == 0;
            sclr = $urandom_range(0, 1023) == 0;
            if ($urandom_range(0, 199) == 0) begin
                case ($urandom_range(0, 3))
                    0: sw.i_target = '0;
                    3: sw.i_target = {4'(10 + $urandom_range(0, 5)), 4'($urandom_range(0, 9))};
                    default: sw.i_target = to_bcd(int'($urandom_range(1, 99)));
                endcase
            end
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_stopwatch_ctrl.md
Name: bcd_stopwatch_ctrl

Overview:
Controller that sequences a chain of NUM_DIGITS modulo-10 BCD digit stages as a start/stop/lap stopwatch with a programmable target alarm. An internal prescaler converts i_clk into a count-enable tick. The FSM gates that tick into the digit chain and handles clear, lap capture, overflow and target-reached events. It sits between user/debounced command pulses and the 7-segment display mux.

Parameters:
NUM_DIGITS, 4, number of cascaded BCD digits (1..8)
TICK_DIV, 1000, i_clk cycles per count tick (>=2)
DIV_WIDTH, 10, prescaler width; must satisfy 2**DIV_WIDTH >= TICK_DIV

Ports:
i_clk  in  1  clock
i_sclr  in  1  synchronous active-high reset
i_start  in  1  pulse: start/resume counting
i_stop  in  1  pulse: pause counting
i_clear  in  1  pulse: zero count, prescaler and lap; go IDLE
i_lap  in  1  pulse: capture current count into o_lap
i_target  in  4*NUM_DIGITS  packed BCD alarm value; digit0 = bits[3:0]; 0 disables alarm
o_cnt  out  4*NUM_DIGITS  packed BCD running count
o_lap  out  4*NUM_DIGITS  last captured count
o_running  out  1  high in RUN
o_done  out  1  high in DONE
o_ovf  out  1  one-cycle pulse on wrap from all-9s to all-0s
o_tick  out  1  one-cycle pulse on each gated count tick (debug/cascade)

Behaviour:
- Reset (i_sclr=1, highest priority): state IDLE; o_cnt=0, o_lap=0, prescaler=0, o_running=0, o_done=0, o_ovf=0, o_tick=0.
- States: IDLE, RUN, PAUSE, DONE. Encoding is free; o_running and o_done are registered decodes.
- Command priority in one cycle: i_clear > i_stop > i_start. i_lap is independent and is evaluated alongside them.
- IDLE: i_start -> RUN. i_stop is ignored.
- RUN: i_stop -> PAUSE, no tick that cycle. i_start is ignored.
- PAUSE: i_start -> RUN. The prescaler holds its value and resumes from it, so no partial tick is lost.
- DONE: o_cnt holds. i_start is ignored. Only i_clear or i_sclr exits.
- i_clear from any state: o_cnt=0, o_lap=0, prescaler=0 -> IDLE, next cycle.
- Prescaler:
  - Advances only in RUN with no i_stop/i_clear that cycle.
  - At TICK_DIV-1 it wraps to 0 and asserts o_tick for exactly one cycle, registered together with the count update.
  - Tick period = TICK_DIV cycles. The first tick occurs TICK_DIV cycles after the cycle i_start is sampled in IDLE.
- Digit chain, on a tick:
  - digit0 increments modulo 10.
  - digit k increments modulo 10 iff all digits below k equal 9 (combinational carry).
  - Digits never take values 10..15.
- Overflow: tick with o_cnt all 9s -> o_cnt all 0s, o_ovf=1 for one cycle; state stays RUN.
- Alarm:
  - If i_target != 0 and the post-tick count equals i_target, move to DONE in the same registered update as the count, so o_done rises the cycle o_cnt shows the target.
  - If i_target changes to a value at or below the current count, the alarm does not fire until after wrap.
  - i_target values with any digit >9 never match.
  - Target match and overflow are checked in the same cycle: an all-zero post-wrap count cannot match, because target 0 disables the alarm.
- Lap: i_lap in any state except reset loads o_lap with the o_cnt value present at that clock edge, which is the pre-tick value if a tick coincides. If i_clear coincides, clear wins and o_lap=0.
- Outputs are fully registered; no combinational path from inputs to outputs.

Test Plan:
(NUM_DIGITS=2, TICK_DIV=4)
- Reset then i_start pulse -> o_running=1 next cycle; first o_tick 4 cycles after start sampled; o_cnt=0x01; after 40 more cycles o_cnt=0x11.
- Run to 0x09, then one tick -> o_cnt=0x10 (carry). At 0x99, one tick -> o_cnt=0x00 and o_ovf high exactly one cycle; o_running stays 1.
- i_target=0x07 -> o_done and o_cnt=0x07 rise on the same cycle; further i_start ignored; i_clear -> o_cnt=0, IDLE.
- Running, prescaler=2: i_stop -> PAUSE, o_cnt frozen for 20 cycles; i_start -> next tick after exactly 2 cycles in RUN (prescaler resumed from 2).
- i_lap at o_cnt=0x35 coinciding with tick -> o_lap=0x35, o_cnt=0x36. i_lap+i_clear same cycle -> o_lap=0, o_cnt=0.
- i_sclr asserted mid-RUN with i_start also high -> all outputs 0, IDLE; i_clear+i_start same cycle -> IDLE, not RUN.
